// File: rtl/com_tr_ctrl.sv
// rtl/com_tr_ctrl.sv - error counters, threshold irq and self-test scheduler for a com_tr detector bank
module com_tr_ctrl #(
  parameter int N_CH       = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int ST_TIMEOUT = 4
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [N_CH-1:0]           en_i,
  input  logic [N_CH-1:0]           error_i,
  input  logic                      clear_i,
  input  logic [CNT_WIDTH-1:0]      threshold_i,
  input  logic                      st_start_i,
  output logic [N_CH-1:0]           inject_o,
  output logic [N_CH*CNT_WIDTH-1:0] count_o,
  output logic [N_CH-1:0]           sticky_o,
  output logic                      irq_o,
  output logic                      st_busy_o,
  output logic                      st_done_o,
  output logic                      st_pass_o,
  output logic [N_CH-1:0]           st_fail_ch_o
);

  localparam int CH_W = $clog2(N_CH + 1);
  localparam int TM_W = $clog2(ST_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_INJECT, S_WAIT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [TM_W-1:0]      timer_q, timer_d;
  logic [N_CH-1:0]      inject_q, inject_d;
  logic [N_CH-1:0]      fail_q, fail_d;
  logic [N_CH-1:0]      sticky_q, sticky_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 irq_q, irq_d;
  logic [CNT_WIDTH-1:0] cnt_q [N_CH];
  logic [CNT_WIDTH-1:0] cnt_d [N_CH];

  logic [N_CH-1:0]      sel;
  logic [N_CH-1:0]      inc;
  logic                 ch_valid;
  logic                 cur_err;
  logic                 cur_en;
  logic                 timeout;

  // Decode the channel currently addressed by the self-test
  always_comb begin
    sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      sel[k] = (ch_q == CH_W'(k));
    end
    ch_valid = (ch_q < CH_W'(N_CH));
    cur_err  = |(error_i & sel);
    cur_en   = |(en_i & sel);
    timeout  = (timer_q == TM_W'(ST_TIMEOUT - 1));
  end

  // Saturating counters, sticky flags and irq; the channel under injection is masked
  always_comb begin
    inc      = error_i & en_i & ~(((state_q == S_INJECT) || (state_q == S_WAIT)) ? sel : '0);
    sticky_d = sticky_q;
    irq_d    = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clear_i) begin
        cnt_d[k] = '0;
      end else if (inc[k]) begin
        sticky_d[k] = 1'b1;
        if (cnt_q[k] != '1) cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
      end
      if (en_i[k] && (threshold_i != '0) && (cnt_d[k] >= threshold_i)) irq_d = 1'b1;
    end
    if (clear_i) sticky_d = '0;
  end

  // Self-test next-state: walk channels, inject, wait for the detector to respond
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (st_start_i) begin
          state_d = S_SEL;
          ch_d    = '0;
        end
      end
      S_SEL: begin
        if (!ch_valid)    state_d = S_DONE;
        else if (!cur_en) ch_d    = ch_q + CH_W'(1);
        else              state_d = S_INJECT;
      end
      S_INJECT: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        if (cur_err || timeout) begin
          state_d = S_SEL;
          ch_d    = ch_q + CH_W'(1);
        end else begin
          timer_d = timer_q + TM_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Self-test outputs, all registered from the upcoming state
  always_comb begin
    inject_d = (state_d == S_INJECT) ? sel : '0;
    busy_d   = (state_d == S_SEL) || (state_d == S_INJECT) || (state_d == S_WAIT);
    done_d   = (state_d == S_DONE);
    fail_d   = fail_q;
    pass_d   = pass_q;
    if ((state_q == S_IDLE) && st_start_i)           fail_d = '0;
    if ((state_q == S_WAIT) && !cur_err && timeout)  fail_d = fail_q | sel;
    if (state_d == S_DONE)                           pass_d = (fail_q == '0);
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      timer_q  <= '0;
      inject_q <= '0;
      fail_q   <= '0;
      sticky_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      irq_q    <= 1'b0;
      for (int k = 0; k < N_CH; k++) cnt_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      timer_q  <= timer_d;
      inject_q <= inject_d;
      fail_q   <= fail_d;
      sticky_q <= sticky_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      irq_q    <= irq_d;
      for (int k = 0; k < N_CH; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt
    assign count_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

  assign inject_o     = inject_q;
  assign sticky_o     = sticky_q;
  assign irq_o        = irq_q;
  assign st_busy_o    = busy_q;
  assign st_done_o    = done_q;
  assign st_pass_o    = pass_q;
  assign st_fail_ch_o = fail_q;

endmodule

// File: tb/tb_com_tr_ctrl.sv
// tb/tb_com_tr_ctrl.sv - scoreboard bench for com_tr_ctrl
module tb_com_tr_ctrl;
  localparam int N = 4;
  localparam int W = 4;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [N-1:0] en = '0, err_drv = '0, resp_mask = '0;
  logic clear = 1'b0, st_start = 1'b0;
  logic [W-1:0] thr = '0;
  logic [N-1:0] error_w, inject, sticky, fail_ch;
  logic [N*W-1:0] count;
  logic irq, busy, done, pass;
  logic [N-1:0] d1, d2;

  always #5 clk = ~clk;

  com_tr_ctrl #(.N_CH(N), .CNT_WIDTH(W), .ST_TIMEOUT(T)) dut (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .error_i(error_w), .clear_i(clear),
    .threshold_i(thr), .st_start_i(st_start), .inject_o(inject), .count_o(count),
    .sticky_o(sticky), .irq_o(irq), .st_busy_o(busy), .st_done_o(done),
    .st_pass_o(pass), .st_fail_ch_o(fail_ch)
  );

  // Detector model: flags an injected glitch two cycles after inject
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d1 <= '0;
      d2 <= '0;
    end else begin
      d1 <= inject;
      d2 <= d1;
    end
  end
  assign error_w = err_drv | (d2 & resp_mask);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [N-1:0] val; int delta; } inj_t;
  typedef struct { logic p; logic [N-1:0] f; int delta; } done_t;
  typedef struct { string name; logic [N*W-1:0] c; logic [N-1:0] s; logic i, b, p; logic [N-1:0] f; } snap_t;

  inj_t  inj_q[$];
  done_t done_q[$];
  snap_t snap_q[$];
  inj_t  ie;
  done_t de;
  snap_t se;

  int checks = 0, errors = 0, done_cnt = 0, last_inj = 0;
  logic chk_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations
  always @(negedge clk) begin
    if (rstn) begin
      if (inject != '0) begin
        if (inj_q.size() == 0) chk("unexpected_inject", 32'(inject), 32'd0);
        else begin
          ie = inj_q.pop_front();
          chk("inject", 32'(inject), 32'(ie.val));
          if (ie.delta != 0) chk("inject_spacing", cyc - last_inj, ie.delta);
        end
        last_inj = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
        else begin
          de = done_q.pop_front();
          chk("done_pass", 32'(pass), 32'(de.p));
          chk("done_fail_ch", 32'(fail_ch), 32'(de.f));
          if (de.delta != 0) chk("done_spacing", cyc - last_inj, de.delta);
        end
      end
      if (chk_req) begin
        if (snap_q.size() == 0) chk("snap_underflow", 32'(chk_req), 32'd0);
        else begin
          se = snap_q.pop_front();
          chk({se.name, "_count"}, 32'(count), 32'(se.c));
          chk({se.name, "_sticky"}, 32'(sticky), 32'(se.s));
          chk({se.name, "_irq"}, 32'(irq), 32'(se.i));
          chk({se.name, "_busy"}, 32'(busy), 32'(se.b));
          chk({se.name, "_pass"}, 32'(pass), 32'(se.p));
          chk({se.name, "_fail_ch"}, 32'(fail_ch), 32'(se.f));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap(input string name, input logic [N*W-1:0] c, input logic [N-1:0] s,
                      input logic i, input logic b, input logic p, input logic [N-1:0] f);
    snap_t e;
    e.name = name; e.c = c; e.s = s; e.i = i; e.b = b; e.p = p; e.f = f;
    snap_q.push_back(e);
    chk_req = 1'b1;
    @(negedge clk);
    #1 chk_req = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    err_drv = m;
    tick(1);
    err_drv = '0;
  endtask

  task automatic exp_inj(input logic [N-1:0] v, input int d);
    inj_t e;
    e.val = v; e.delta = d;
    inj_q.push_back(e);
  endtask

  task automatic exp_done(input logic p, input logic [N-1:0] f, input int d);
    done_t e;
    e.p = p; e.f = f; e.delta = d;
    done_q.push_back(e);
  endtask

  task automatic start_st();
    st_start = 1'b1;
    tick(1);
    st_start = 1'b0;
  endtask

  task automatic wait_done(input int c0);
    int n = 0;
    while (done_cnt == c0 && n < 300) begin
      tick(1);
      n++;
    end
    if (done_cnt == c0) begin
      checks++;
      errors++;
      $display("FAIL st_done_timeout: no st_done_o within %0d cycles", n);
    end
  endtask

  initial begin
    int c0, n;
    tick(2);
    rstn = 1'b1;
    tick(1);
    snap("reset", '0, '0, 0, 0, 0, '0);

    // disabled channels never count
    for (int i = 0; i < 1000; i++) begin
      err_drv = N'($urandom);
      tick(1);
    end
    err_drv = '0;
    tick(1);
    snap("disabled", '0, '0, 0, 0, 0, '0);

    // threshold irq
    en = 4'b0001; thr = 4'd3;
    pulse(4'b0001);
    snap("thr_1", 16'h0001, 4'b0001, 0, 0, 0, '0);
    pulse(4'b0001);
    pulse(4'b0001);
    snap("thr_3", 16'h0003, 4'b0001, 1, 0, 0, '0);
    en = 4'b0000; tick(1);
    snap("thr_disable", 16'h0003, 4'b0001, 0, 0, 0, '0);
    en = 4'b0001; tick(1);
    snap("thr_reenable", 16'h0003, 4'b0001, 1, 0, 0, '0);
    clear = 1'b1; tick(1); clear = 1'b0;
    snap("thr_clear", '0, '0, 0, 0, 0, '0);

    // saturation and clear priority
    en = 4'b0010; thr = 4'd0;
    err_drv = 4'b0010; tick(20); err_drv = '0;
    snap("sat", 16'h00F0, 4'b0010, 0, 0, 0, '0);
    thr = 4'd15; tick(1);
    snap("sat_thr15", 16'h00F0, 4'b0010, 1, 0, 0, '0);
    thr = 4'd0; tick(1);
    snap("sat_thr0", 16'h00F0, 4'b0010, 0, 0, 0, '0);
    err_drv = 4'b0010; clear = 1'b1; tick(1); err_drv = '0; clear = 1'b0;
    snap("clear_vs_err", '0, '0, 0, 0, 0, '0);

    // self-test with nothing enabled
    en = 4'b0000; resp_mask = 4'b1111;
    exp_done(1'b1, 4'b0000, 0);
    c0 = done_cnt; start_st(); wait_done(c0);
    snap("st_none", '0, '0, 0, 0, 1, '0);

    // healthy self-test on 1011
    en = 4'b1011;
    exp_inj(4'b0001, 0); exp_inj(4'b0010, 4); exp_inj(4'b1000, 5);
    exp_done(1'b1, 4'b0000, 4);
    c0 = done_cnt; start_st();
    snap("st_busy", '0, '0, 0, 1, 1, '0);
    wait_done(c0);
    snap("st_1011", '0, '0, 0, 0, 1, '0);

    // channel 2 never responds
    en = 4'b1111; resp_mask = 4'b1011;
    exp_inj(4'b0001, 0); exp_inj(4'b0010, 4); exp_inj(4'b0100, 4); exp_inj(4'b1000, 6);
    exp_done(1'b0, 4'b0100, 4);
    c0 = done_cnt; start_st(); wait_done(c0);
    snap("st_fail", '0, '0, 0, 0, 0, 4'b0100);

    // reset during WAIT, then a full run
    resp_mask = 4'b1111;
    exp_inj(4'b0001, 0);
    start_st();
    n = 0;
    while (inj_q.size() != 0 && n < 50) begin
      tick(1);
      n++;
    end
    rstn = 1'b0;
    tick(3);
    rstn = 1'b1;
    tick(1);
    snap("mid_reset", '0, '0, 0, 0, 0, '0);
    chk("mid_reset_inject", 32'(inject), 32'd0);
    exp_inj(4'b0001, 0); exp_inj(4'b0010, 4); exp_inj(4'b0100, 4); exp_inj(4'b1000, 4);
    exp_done(1'b1, 4'b0000, 4);
    c0 = done_cnt; start_st(); wait_done(c0);
    snap("st_after_reset", '0, '0, 0, 0, 1, '0);

    tick(2);
    chk("inj_q_left", inj_q.size(), 0);
    chk("done_q_left", done_q.size(), 0);
    chk("snap_q_left", snap_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
